// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO button-conditioning bank.
// Edge-mode encodings select which debounced transitions latch the sticky flag.
package gpio_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  // Width for a counter spanning 0..n-1, never narrower than one bit.
  function automatic int count_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button conditioner: synchroniser, stability counter, debounced level,
// registered edge pulses and a sticky, software-clearable event flag.
module debounce_channel
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 65536,
  parameter bit INVERT_BIT    = 1'b0,
  parameter int EDGE_MODE     = EDGE_RISE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic clear,
  output logic level,
  output logic rise,
  output logic fall,
  output logic pending
);

  localparam int COUNT_W = count_width(STABLE_CYCLES);
  localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(STABLE_CYCLES - 1);
  localparam bit SET_ON_RISE = (EDGE_MODE == EDGE_RISE) || (EDGE_MODE == EDGE_BOTH);
  localparam bit SET_ON_FALL = (EDGE_MODE == EDGE_FALL) || (EDGE_MODE == EDGE_BOTH);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [COUNT_W-1:0]     count_q, count_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   pending_q, pending_d;
  logic                   sync_bit;
  logic                   flag_set;

  // Inversion is applied before the first stage so everything downstream is active-high.
  assign sync_bit = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw ^ INVERT_BIT};
  end

  always_comb begin
    count_d = count_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync_bit != level_q) begin
      if (count_q == COUNT_MAX) begin
        level_d = sync_bit;
        count_d = '0;
        rise_d  = sync_bit;
        fall_d  = ~sync_bit;
      end else begin
        count_d = count_q + 1'b1;
      end
    end else begin
      // Any return to the current level restarts qualification from zero.
      count_d = '0;
    end
  end

  always_comb begin
    flag_set  = (rise_d & SET_ON_RISE) | (fall_d & SET_ON_FALL);
    pending_d = pending_q;
    if (flag_set) begin
      pending_d = 1'b1;
    end else if (clear) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      count_q   <= '0;
      level_q   <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      count_q   <= count_d;
      level_q   <= level_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      pending_q <= pending_d;
    end
  end

  assign level   = level_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign pending = pending_q;

endmodule

// File: rtl/gpio_debounce.sv
// Parametrised bank of independent button conditioners with a combined
// "any event pending" summary for interrupt generation.
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int                  CHANNELS      = 2,
  parameter int                  SYNC_STAGES   = 2,
  parameter int                  STABLE_CYCLES = 65536,
  parameter logic [CHANNELS-1:0] INVERT        = {CHANNELS{1'b0}},
  parameter int                  EDGE_MODE     = EDGE_RISE
) (
  input  logic                CLK,
  input  logic                BTN_N,
  input  logic [CHANNELS-1:0] btn_raw,
  input  logic [CHANNELS-1:0] clear,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] pending,
  output logic                any_pending
);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      debounce_channel #(
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES),
        .INVERT_BIT    (INVERT[gi]),
        .EDGE_MODE     (EDGE_MODE)
      ) u_chan (
        .clk     (CLK),
        .rst_n   (BTN_N),
        .raw     (btn_raw[gi]),
        .clear   (clear[gi]),
        .level   (level[gi]),
        .rise    (rise[gi]),
        .fall    (fall[gi]),
        .pending (pending[gi])
      );
    end
  endgenerate

  assign any_pending = |pending;

endmodule
